// File: rtl/data_mem_arb_pkg.sv
// rtl/data_mem_arb_pkg.sv - shared types and helpers for the data RAM arbiter
// Contents:
//   arb_state_t      arbiter FSM state (IDLE, EXT_BURST)
//   owner_t          access owner tag (OWN_NONE, OWN_CPU, OWN_EXT)
//   burst_cnt_width  width of a counter able to hold 0..max_burst
package data_mem_arb_pkg;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        EXT_BURST = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_EXT  = 2'd2
    } owner_t;

    function automatic int burst_cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/arb_burst_limiter.sv
// rtl/arb_burst_limiter.sv - counts locked external beats and flags the burst limit
// Ports:
//   clock, reset  system clock, synchronous active-high reset
//   beat          locked external grant this cycle (counts one beat)
//   clear         burst ends at this edge; counter returns to zero
//   limit_hit     this beat takes the count to MAX_BURST (combinational)
module arb_burst_limiter #(
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic beat,
    input  logic clear,
    output logic limit_hit
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    logic [CNT_W-1:0] burst_cnt;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc   = burst_cnt + CNT_W'(1);
    assign limit_hit = beat && (cnt_inc == MAX_CNT);

    // clear wins over beat so the beat that reaches the limit leaves zero behind
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            burst_cnt <= '0;
        end else if (beat) begin
            burst_cnt <= cnt_inc;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - single-port data RAM arbiter between CPU and external requester
// Build option: MEM_ARB_RR_EN selects round-robin between requesters in IDLE
// (default: fixed CPU priority). Locked external bursts behave the same in both builds.
// Ports:
//   clock, reset                       system clock, synchronous active-high reset
//   cpu_req/we/addr/wdata              CPU request side
//   cpu_gnt, cpu_stall                 CPU grant (combinational) and pipeline stall
//   cpu_rvalid, cpu_rdata              CPU read return, one cycle after a read grant
//   ext_req/lock/we/addr/wdata         external request side, lock holds ownership
//   ext_gnt, ext_rvalid, ext_rdata     external grant and read return
//   mem_we/addr/wdata, mem_rdata       RAM command and 1-cycle-latency read data
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int ADDR_SIZE = 18,
    parameter int WORD_SIZE = 18,
    parameter int MAX_BURST = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [ADDR_SIZE-1:0] cpu_addr,
    input  logic [WORD_SIZE-1:0] cpu_wdata,
    output logic                 cpu_gnt,
    output logic                 cpu_stall,
    output logic                 cpu_rvalid,
    output logic [WORD_SIZE-1:0] cpu_rdata,
    input  logic                 ext_req,
    input  logic                 ext_lock,
    input  logic                 ext_we,
    input  logic [ADDR_SIZE-1:0] ext_addr,
    input  logic [WORD_SIZE-1:0] ext_wdata,
    output logic                 ext_gnt,
    output logic                 ext_rvalid,
    output logic [WORD_SIZE-1:0] ext_rdata,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata
);

    localparam int CNT_W = burst_cnt_width(MAX_BURST);

    arb_state_t state;
    arb_state_t state_next;
    owner_t     rd_owner;
    logic       limit_hit;
    logic       burst_beat;
    logic       burst_clear;

`ifdef MEM_ARB_RR_EN
    owner_t     last_owner;
`endif

    // Grant selection; nothing is granted while reset is held
    always_comb begin
        cpu_gnt = 1'b0;
        ext_gnt = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
`ifdef MEM_ARB_RR_EN
                    if (cpu_req && ext_req) begin
                        if (last_owner == OWN_CPU) begin
                            ext_gnt = 1'b1;
                        end else begin
                            cpu_gnt = 1'b1;
                        end
                    end else begin
                        cpu_gnt = cpu_req;
                        ext_gnt = ext_req;
                    end
`else
                    cpu_gnt = cpu_req;
                    ext_gnt = ext_req && !cpu_req;
`endif
                end
                EXT_BURST: begin
                    ext_gnt = ext_req;
                end
                default: begin
                    cpu_gnt = 1'b0;
                    ext_gnt = 1'b0;
                end
            endcase
        end
    end

    assign cpu_stall = cpu_req && !cpu_gnt && !reset;

    // RAM command: external values only when external wins, CPU values otherwise
    assign mem_we    = (cpu_gnt && cpu_we) || (ext_gnt && ext_we);
    assign mem_addr  = ext_gnt ? ext_addr  : cpu_addr;
    assign mem_wdata = ext_gnt ? ext_wdata : cpu_wdata;

    assign burst_beat = ext_gnt && ext_lock;

    // A lock beat that already reaches the limit (MAX_BURST == 1) never enters EXT_BURST
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (burst_beat && !limit_hit) begin
                    state_next = EXT_BURST;
                end
            end
            EXT_BURST: begin
                if (!ext_req || !ext_lock || limit_hit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign burst_clear = (state_next == IDLE);

    arb_burst_limiter #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) u_limiter (
        .clock     (clock),
        .reset     (reset),
        .beat      (burst_beat),
        .clear     (burst_clear),
        .limit_hit (limit_hit)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            rd_owner <= OWN_NONE;
        end else begin
            state <= state_next;
            if (cpu_gnt && !cpu_we) begin
                rd_owner <= OWN_CPU;
            end else if (ext_gnt && !ext_we) begin
                rd_owner <= OWN_EXT;
            end else begin
                rd_owner <= OWN_NONE;
            end
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            last_owner <= OWN_CPU;
        end else if (cpu_gnt) begin
            last_owner <= OWN_CPU;
        end else if (ext_gnt) begin
            last_owner <= OWN_EXT;
        end
    end
`endif

    // Read data is broadcast; rvalid tells which requester owns it
    assign cpu_rvalid = (rd_owner == OWN_CPU);
    assign ext_rvalid = (rd_owner == OWN_EXT);
    assign cpu_rdata  = mem_rdata;
    assign ext_rdata  = mem_rdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - directed self-checking bench for data_mem_arbiter
module tb_data_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
    logic [17:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        ext_req, ext_lock, ext_we, ext_gnt, ext_rvalid;
    logic [17:0] ext_addr, ext_wdata, ext_rdata;
    logic        mem_we;
    logic [17:0] mem_addr, mem_wdata, mem_rdata;
    logic [17:0] ram [0:255];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    data_mem_arbiter #(.ADDR_SIZE(18), .WORD_SIZE(18), .MAX_BURST(8)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ext_req(ext_req), .ext_lock(ext_lock), .ext_we(ext_we), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Single-port synchronous RAM, 1-cycle read latency
    always @(posedge clock) begin
        if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= ram[mem_addr[7:0]];
    end

    task automatic drive_idle();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ext_req = 0; ext_lock = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0;
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1; cpu_req = 1; cpu_we = 1; cpu_addr = 18'h5; cpu_wdata = 18'h7;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); #1;
            n_cmp++; if (cpu_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_gnt[%0d]: got %b want 0", i, cpu_gnt); end
            n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we[%0d]: got %b want 0", i, mem_we); end
            n_cmp++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_stall[%0d]: got %b want 0", i, cpu_stall); end
            n_cmp++; if ({cpu_rvalid, ext_rvalid} !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid[%0d]: got %b want 00", i, {cpu_rvalid, ext_rvalid}); end
        end
        @(negedge clock);
        reset = 0; cpu_we = 0; #1;
        n_cmp++; if (cpu_gnt !== 1'b1) begin n_fail++; $display("FAIL post_reset_cpu_gnt: got %b want 1", cpu_gnt); end
        n_cmp++; if (ext_gnt !== 1'b0) begin n_fail++; $display("FAIL post_reset_ext_gnt: got %b want 0", ext_gnt); end
        drive_idle();
    endtask

    task automatic test_cpu_write_read();
        @(negedge clock);
        cpu_addr = 18'h00155; ext_addr = 18'h002AA; #1;
        n_cmp++; if (mem_addr !== 18'h00155) begin n_fail++; $display("FAIL nogrant_mem_addr: got %h want 00155", mem_addr); end
        n_cmp++; if ({mem_we, cpu_gnt, ext_gnt} !== 3'b000) begin n_fail++; $display("FAIL nogrant_we_gnt: got %b want 000", {mem_we, cpu_gnt, ext_gnt}); end
        @(negedge clock);
        cpu_req = 1; cpu_we = 1; cpu_addr = 18'h00010; cpu_wdata = 18'h3FFFF; #1;
        n_cmp++; if ({cpu_gnt, mem_we} !== 2'b11) begin n_fail++; $display("FAIL wr_gnt_we: got %b want 11", {cpu_gnt, mem_we}); end
        n_cmp++; if (mem_addr !== 18'h00010 || mem_wdata !== 18'h3FFFF) begin n_fail++; $display("FAIL wr_cmd: got %h/%h want 00010/3ffff", mem_addr, mem_wdata); end
        @(negedge clock);
        cpu_we = 0; #1;
        n_cmp++; if ({cpu_gnt, mem_we} !== 2'b10) begin n_fail++; $display("FAIL rd_gnt_we: got %b want 10", {cpu_gnt, mem_we}); end
        n_cmp++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL wr_no_rvalid: got %b want 0", cpu_rvalid); end
        @(negedge clock);
        cpu_req = 0; #1;
        n_cmp++; if (cpu_rvalid !== 1'b1 || ext_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_rvalid: got cpu=%b ext=%b want 1/0", cpu_rvalid, ext_rvalid); end
        n_cmp++; if (cpu_rdata !== 18'h3FFFF) begin n_fail++; $display("FAIL rd_data: got %h want 3ffff", cpu_rdata); end
        @(negedge clock); #1;
        n_cmp++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_rvalid_pulse: got %b want 0", cpu_rvalid); end
        drive_idle();
    endtask

    task automatic test_both_request();
        logic [3:0] exp_cpu;
`ifdef MEM_ARB_RR_EN
        exp_cpu = 4'b1010;   // last grant was CPU, so EXT first, then alternate
`else
        exp_cpu = 4'b1111;
`endif
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            cpu_req = 1; cpu_addr = 18'h10; ext_req = 1; ext_addr = 18'h11; #1;
            n_cmp++; if (cpu_gnt !== exp_cpu[i] || ext_gnt !== !exp_cpu[i]) begin n_fail++; $display("FAIL both_gnt[%0d]: got cpu=%b ext=%b want cpu=%b", i, cpu_gnt, ext_gnt, exp_cpu[i]); end
            n_cmp++; if (cpu_stall !== !exp_cpu[i]) begin n_fail++; $display("FAIL both_stall[%0d]: got %b want %b", i, cpu_stall, !exp_cpu[i]); end
        end
        drive_idle();
    endtask

    task automatic test_burst_limit();
        int beat;
        for (int s = 0; s < 13; s++) begin
            @(negedge clock);
            beat = (s < 8) ? s : s - 1;
            ext_req = 1; ext_we = 1; ext_lock = (beat < 11);
            ext_addr = 18'h40 + 18'(beat); ext_wdata = 18'h100 + 18'(beat);
            cpu_req = (s >= 1 && s <= 8); cpu_addr = 18'h10; #1;
            if (s == 8) begin
                n_cmp++; if ({cpu_gnt, ext_gnt, cpu_stall} !== 3'b100) begin n_fail++; $display("FAIL burst_cpu_slot: got gnt/egnt/stall=%b want 100", {cpu_gnt, ext_gnt, cpu_stall}); end
                n_cmp++; if (mem_addr !== 18'h10) begin n_fail++; $display("FAIL burst_cpu_addr: got %h want 00010", mem_addr); end
            end else begin
                n_cmp++; if ({cpu_gnt, ext_gnt} !== 2'b01) begin n_fail++; $display("FAIL burst_ext_gnt[%0d]: got cpu/ext=%b want 01", s, {cpu_gnt, ext_gnt}); end
                n_cmp++; if (cpu_stall !== cpu_req) begin n_fail++; $display("FAIL burst_stall[%0d]: got %b want %b", s, cpu_stall, cpu_req); end
            end
        end
        drive_idle();
    endtask

    task automatic test_alternating_reads();
        @(negedge clock);
        cpu_req = 1; cpu_we = 1; cpu_addr = 18'h20; cpu_wdata = 18'h12345;
        @(negedge clock);
        cpu_addr = 18'h21; cpu_wdata = 18'h2ABCD;
        @(negedge clock);
        drive_idle(); ext_req = 1; ext_addr = 18'h20; #1;
        n_cmp++; if (ext_gnt !== 1'b1) begin n_fail++; $display("FAIL alt_ext_gnt: got %b want 1", ext_gnt); end
        @(negedge clock);
        ext_req = 0; cpu_req = 1; cpu_addr = 18'h21; #1;
        n_cmp++; if (cpu_gnt !== 1'b1) begin n_fail++; $display("FAIL alt_cpu_gnt: got %b want 1", cpu_gnt); end
        n_cmp++; if ({ext_rvalid, cpu_rvalid} !== 2'b10 || ext_rdata !== 18'h12345) begin n_fail++; $display("FAIL alt_ext_ret: got v=%b d=%h want 10/12345", {ext_rvalid, cpu_rvalid}, ext_rdata); end
        @(negedge clock);
        cpu_req = 0; #1;
        n_cmp++; if ({ext_rvalid, cpu_rvalid} !== 2'b01 || cpu_rdata !== 18'h2ABCD) begin n_fail++; $display("FAIL alt_cpu_ret: got v=%b d=%h want 01/2abcd", {ext_rvalid, cpu_rvalid}, cpu_rdata); end
        drive_idle();
    endtask

    task automatic test_reset_mid_burst();
        int ext_cnt;
        logic got_cpu;
        @(negedge clock);
        ext_req = 1; ext_lock = 1; ext_addr = 18'h20; #1;
        n_cmp++; if (ext_gnt !== 1'b1) begin n_fail++; $display("FAIL mid_beat1: got %b want 1", ext_gnt); end
        @(negedge clock);
        ext_addr = 18'h21; #1;
        n_cmp++; if (ext_gnt !== 1'b1) begin n_fail++; $display("FAIL mid_beat2: got %b want 1", ext_gnt); end
        @(negedge clock);
        reset = 1; ext_addr = 18'h22; #1;
        n_cmp++; if ({ext_gnt, cpu_gnt, mem_we} !== 3'b000) begin n_fail++; $display("FAIL mid_reset_gnt: got %b want 000", {ext_gnt, cpu_gnt, mem_we}); end
        @(negedge clock);
        reset = 0; ext_req = 0; ext_lock = 0; cpu_req = 1; cpu_addr = 18'h21; #1;
        n_cmp++; if (cpu_gnt !== 1'b1) begin n_fail++; $display("FAIL mid_cpu_gnt: got %b want 1", cpu_gnt); end
        n_cmp++; if ({ext_rvalid, cpu_rvalid} !== 2'b00) begin n_fail++; $display("FAIL mid_stale_rvalid: got %b want 00", {ext_rvalid, cpu_rvalid}); end
        // a fresh burst must again run exactly MAX_BURST beats before the CPU slot
        ext_cnt = 0; got_cpu = 0;
        for (int k = 0; k < 12 && !got_cpu; k++) begin
            @(negedge clock);
            ext_req = 1; ext_lock = 1; ext_we = 1; ext_addr = 18'h60; cpu_req = (k > 0); #1;
            if (k == 0) begin
                n_cmp++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 18'h2ABCD) begin n_fail++; $display("FAIL mid_cpu_ret: got v=%b d=%h want 1/2abcd", cpu_rvalid, cpu_rdata); end
            end
            if (cpu_gnt) got_cpu = 1;
            else if (ext_gnt) ext_cnt++;
        end
        n_cmp++; if (got_cpu !== 1'b1) begin n_fail++; $display("FAIL mid_cpu_slot: got %b want 1", got_cpu); end
        n_cmp++; if (ext_cnt != 8) begin n_fail++; $display("FAIL mid_burst_len: got %0d want 8", ext_cnt); end
        drive_idle();
    endtask

    initial begin
        for (int a = 0; a < 256; a++) ram[a] = '0;
        test_reset();
        test_cpu_write_read();
        test_both_request();
        test_burst_limit();
        test_alternating_reads();
        test_reset_mid_burst();
        @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
